// File: rtl/jt51_kon_pkg.sv
// Shared constants, slot layout and helpers for the parametrised key-on sequencer.
package jt51_kon_pkg;

   localparam int CH_W_DEF = 3;
   localparam int OP_W_DEF = 2;

   // Slot layout at default geometry: channel is the fast-moving low field.
   typedef struct packed {
      logic [OP_W_DEF-1:0] op;
      logic [CH_W_DEF-1:0] ch;
   } kon_slot_t;

   function automatic logic [7:0] bitrev(input logic [7:0] idx, input int width);
      logic [7:0] r;
      r = '0;
      for (int i = 0; i < 8; i++) begin
         if (i < width) r[i] = idx[width-1-i];
      end
      return r;
   endfunction

endpackage

// File: rtl/jt51_sh_rst.sv
// Circular shift register with slot-rate enable and asynchronous active-low clear.
module jt51_sh_rst #(
   parameter int W     = 2,
   parameter int DEPTH = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clk_en,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout
);

   logic [W-1:0] mem_q [DEPTH];
   logic [W-1:0] mem_d [DEPTH];

   always_comb begin
      mem_d[0] = din;
      for (int i = 1; i < DEPTH; i++) begin
         mem_d[i] = mem_q[i-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (clk_en) begin
         mem_q <= mem_d;
      end
   end

   assign dout = mem_q[DEPTH-1];

endmodule

// File: rtl/jt51_kon_gen.sv
// Key-on sequencer: slot counter, handshaked key writes, CSM forcing and
// per-slot key level / edge pulses for the envelope generator.
module jt51_kon_gen
   import jt51_kon_pkg::*;
#(
   parameter int CH_W   = CH_W_DEF,
   parameter int OP_W   = OP_W_DEF,
   parameter int CSM_EN = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clk_en,
   input  logic                 kon_valid,
   output logic                 kon_ready,
   input  logic [CH_W-1:0]      kon_ch,
   input  logic [(1<<OP_W)-1:0] kon_op,
   input  logic                 csm,
   input  logic                 overflow_A,
   output logic [CH_W-1:0]      out_ch,
   output logic [OP_W-1:0]      out_op,
   output logic                 keyon,
   output logic                 kon_pulse,
   output logic                 koff_pulse
);

   localparam int S     = OP_W + CH_W;
   localparam int SLOTS = 1 << S;
   localparam int MW    = 1 << OP_W;

   logic [S-1:0]    cnt_q, cnt_d;
   logic            pending_q, pending_d;
   logic [CH_W-1:0] ch_q, ch_d;
   logic [MW-1:0]   mask_q, mask_d;
   logic [S-1:0]    acc_q, acc_d;
   logic            keyon_q, keyon_d;
   logic            kon_pulse_q, kon_pulse_d;
   logic            koff_pulse_q, koff_pulse_d;
   logic [CH_W-1:0] out_ch_q, out_ch_d;
   logic [OP_W-1:0] out_op_q, out_op_d;

   logic [CH_W-1:0] cur_ch;
   logic [OP_W-1:0] cur_op;
   logic [OP_W-1:0] rev_op;
   logic            accept;
   logic            wr_hit;
   logic            wr_bit;
   logic            key_new;
   logic            eff;
   logic            csm_force;
   logic [1:0]      sh_din;
   logic [1:0]      sh_dout;

   assign kon_ready = ~pending_q;

   // Each shifter entry is {stored_key, prev_out}; the word leaving the shifter
   // belongs to the slot the counter currently addresses.
   jt51_sh_rst #(
      .W     (2),
      .DEPTH (SLOTS)
   ) u_sh (
      .clk    (clk),
      .rst_n  (rst_n),
      .clk_en (clk_en),
      .din    (sh_din),
      .dout   (sh_dout)
   );

   always_comb begin
      cur_op  = cnt_q[S-1:CH_W];
      cur_ch  = cnt_q[CH_W-1:0];
      rev_op  = OP_W'(bitrev(8'(cur_op), OP_W));
      accept  = kon_valid & kon_ready & clk_en;
      // The acceptance cycle uses the incoming write directly so its own slot updates too.
      wr_hit  = (accept && (kon_ch == cur_ch)) || (pending_q && (ch_q == cur_ch));
      wr_bit  = accept ? kon_op[rev_op] : mask_q[rev_op];
      key_new = wr_hit ? wr_bit : sh_dout[1];
      eff     = key_new | csm_force;
      sh_din  = {key_new, eff};

      cnt_d     = cnt_q + S'(1);
      pending_d = pending_q;
      ch_d      = ch_q;
      mask_d    = mask_q;
      acc_d     = acc_q;
      if (accept) begin
         pending_d = 1'b1;
         ch_d      = kon_ch;
         mask_d    = kon_op;
         acc_d     = cnt_q;
      end else if (pending_q && (cnt_q == acc_q)) begin
         pending_d = 1'b0;
      end

      keyon_d      = eff;
      kon_pulse_d  = eff & ~sh_dout[0];
      koff_pulse_d = ~eff & sh_dout[0];
      out_ch_d     = cur_ch;
      out_op_d     = cur_op;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q        <= '0;
         pending_q    <= 1'b0;
         ch_q         <= '0;
         mask_q       <= '0;
         acc_q        <= '0;
         keyon_q      <= 1'b0;
         kon_pulse_q  <= 1'b0;
         koff_pulse_q <= 1'b0;
         out_ch_q     <= '0;
         out_op_q     <= '0;
      end else if (clk_en) begin
         cnt_q        <= cnt_d;
         pending_q    <= pending_d;
         ch_q         <= ch_d;
         mask_q       <= mask_d;
         acc_q        <= acc_d;
         keyon_q      <= keyon_d;
         kon_pulse_q  <= kon_pulse_d;
         koff_pulse_q <= koff_pulse_d;
         out_ch_q     <= out_ch_d;
         out_op_q     <= out_op_d;
      end
   end

   // CSM window lasts one full sweep from the most recent overflow.
   if (CSM_EN != 0) begin : g_csm
      logic         csm_act_q, csm_act_d;
      logic [S-1:0] ov_q, ov_d;

      always_comb begin
         csm_act_d = csm_act_q;
         ov_d      = ov_q;
         if (overflow_A) begin
            csm_act_d = 1'b1;
            ov_d      = cnt_q;
         end else if (csm_act_q && (cnt_q == ov_q)) begin
            csm_act_d = 1'b0;
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            csm_act_q <= 1'b0;
            ov_q      <= '0;
         end else if (clk_en) begin
            csm_act_q <= csm_act_d;
            ov_q      <= ov_d;
         end
      end

      assign csm_force = csm & csm_act_q;
   end else begin : g_no_csm
      assign csm_force = 1'b0;
   end

   assign keyon      = keyon_q;
   assign kon_pulse  = kon_pulse_q;
   assign koff_pulse = koff_pulse_q;
   assign out_ch     = out_ch_q;
   assign out_op     = out_op_q;

endmodule

// File: tb/tb_jt51_kon_gen.sv
// Directed bench for jt51_kon_gen at default geometry plus a CH_W=2/OP_W=3 instance.
module tb_jt51_kon_gen;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       clk_en;
   logic       kon_valid;
   logic [2:0] kon_ch;
   logic [3:0] kon_op;
   logic       csm;
   logic       overflow_A;
   logic       kon_ready;
   logic [2:0] out_ch;
   logic [1:0] out_op;
   logic       keyon, kon_pulse, koff_pulse;

   logic       kon2_valid;
   logic [1:0] kon2_ch;
   logic [7:0] kon2_op;
   logic       kon2_ready;
   logic [1:0] out2_ch;
   logic [2:0] out2_op;
   logic       keyon2, kon2_pulse, koff2_pulse;

   int         n_err = 0;
   int         n_checks = 0;
   logic [4:0] exp_cnt;
   logic [4:0] out_slot;
   logic       hit;
   logic       acc_hit;

   jt51_kon_gen dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .clk_en     (clk_en),
      .kon_valid  (kon_valid),
      .kon_ready  (kon_ready),
      .kon_ch     (kon_ch),
      .kon_op     (kon_op),
      .csm        (csm),
      .overflow_A (overflow_A),
      .out_ch     (out_ch),
      .out_op     (out_op),
      .keyon      (keyon),
      .kon_pulse  (kon_pulse),
      .koff_pulse (koff_pulse)
   );

   jt51_kon_gen #(.CH_W(2), .OP_W(3), .CSM_EN(1)) dut2 (
      .clk        (clk),
      .rst_n      (rst_n),
      .clk_en     (clk_en),
      .kon_valid  (kon2_valid),
      .kon_ready  (kon2_ready),
      .kon_ch     (kon2_ch),
      .kon_op     (kon2_op),
      .csm        (1'b0),
      .overflow_A (1'b0),
      .out_ch     (out2_ch),
      .out_op     (out2_op),
      .keyon      (keyon2),
      .kon_pulse  (kon2_pulse),
      .koff_pulse (koff2_pulse)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
      if (clk_en) begin
         out_slot = exp_cnt;
         exp_cnt  = exp_cnt + 5'd1;
      end
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [2:0] ch, input logic [3:0] m);
      kon_valid = v;
      kon_ch    = ch;
      kon_op    = m;
   endtask

   task automatic checkDut1(input string tag, input logic k, input logic kp, input logic kf);
      checkOutput({tag, "_slot"}, {27'd0, out_op, out_ch}, {27'd0, out_slot});
      checkOutput({tag, "_key"}, {29'd0, keyon, kon_pulse, koff_pulse}, {29'd0, k, kp, kf});
   endtask

   initial begin
      rst_n      = 1'b0;
      clk_en     = 1'b1;
      csm        = 1'b0;
      overflow_A = 1'b0;
      kon2_valid = 1'b0;
      kon2_ch    = '0;
      kon2_op    = '0;
      applyStimulus(1'b0, 3'd0, 4'd0);
      exp_cnt    = '0;
      out_slot   = '0;

      #12;
      checkOutput("reset_rdy", {31'd0, kon_ready}, 32'd1);
      checkOutput("reset_out", {24'd0, keyon, kon_pulse, koff_pulse, out_op, out_ch}, 32'd0);
      checkOutput("reset_rdy2", {31'd0, kon2_ready}, 32'd1);
      #6 rst_n = 1'b1;

      $display("[TB] idle sweep");
      for (int k = 1; k <= 64; k++) begin
         tick();
         checkDut1("idle", 1'b0, 1'b0, 1'b0);
         checkOutput("idle_rdy", {31'd0, kon_ready}, 32'd1);
      end

      // ch5 mask 0101: op0 -> bit0, op1 -> bit2 => slots 5 and 13
      $display("[TB] key-on ch5");
      applyStimulus(1'b1, 3'd5, 4'b0101);
      for (int k = 1; k <= 64; k++) begin
         tick();
         if (k == 1)  applyStimulus(1'b1, 3'd2, 4'b1111);
         if (k == 10) applyStimulus(1'b0, 3'd0, 4'd0);
         hit = (out_slot == 5'd5) || (out_slot == 5'd13);
         checkDut1("kon5", hit, hit && (k <= 32), 1'b0);
         checkOutput("kon5_rdy", {31'd0, kon_ready}, {31'd0, k > 32});
      end

      $display("[TB] key-off ch5");
      applyStimulus(1'b1, 3'd5, 4'b0000);
      for (int k = 1; k <= 64; k++) begin
         tick();
         if (k == 1) applyStimulus(1'b0, 3'd0, 4'd0);
         hit = (out_slot == 5'd5) || (out_slot == 5'd13);
         checkDut1("koff5", 1'b0, 1'b0, hit && (k <= 32));
      end

      $display("[TB] overflow with csm off");
      overflow_A = 1'b1;
      for (int k = 1; k <= 34; k++) begin
         tick();
         if (k == 1) overflow_A = 1'b0;
         checkDut1("csm_off", 1'b0, 1'b0, 1'b0);
      end

      $display("[TB] csm single overflow");
      csm        = 1'b1;
      overflow_A = 1'b1;
      for (int k = 1; k <= 70; k++) begin
         tick();
         if (k == 1) overflow_A = 1'b0;
         checkDut1("csm1", (k >= 2) && (k <= 33), (k >= 2) && (k <= 33), (k >= 34) && (k <= 65));
      end

      $display("[TB] csm extended window");
      overflow_A = 1'b1;
      for (int k = 1; k <= 80; k++) begin
         tick();
         if (k == 1)  overflow_A = 1'b0;
         if (k == 10) overflow_A = 1'b1;
         if (k == 11) overflow_A = 1'b0;
         checkDut1("csm2", (k >= 2) && (k <= 43), (k >= 2) && (k <= 33), (k >= 44) && (k <= 75));
      end
      csm = 1'b0;

      $display("[TB] clk_en freeze");
      applyStimulus(1'b1, 3'd0, 4'b0001);
      tick();
      applyStimulus(1'b0, 3'd0, 4'd0);
      acc_hit = (out_slot == 5'd0);
      checkDut1("frz_acc", acc_hit, acc_hit, 1'b0);
      checkOutput("frz_acc_rdy", {31'd0, kon_ready}, 32'd0);
      clk_en = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         tick();
         checkDut1("frz_hold", acc_hit, acc_hit, 1'b0);
         checkOutput("frz_rdy", {31'd0, kon_ready}, 32'd0);
      end
      clk_en = 1'b1;
      for (int k = 2; k <= 40; k++) begin
         tick();
         hit = (out_slot == 5'd0);
         checkDut1("frz_run", hit, hit && (k <= 32), 1'b0);
         checkOutput("frz_run_rdy", {31'd0, kon_ready}, {31'd0, k > 32});
      end

      $display("[TB] reset mid-write");
      applyStimulus(1'b1, 3'd5, 4'b1111);
      tick();
      applyStimulus(1'b0, 3'd0, 4'd0);
      for (int k = 2; k <= 10; k++) begin
         tick();
         checkOutput("mw_rdy", {31'd0, kon_ready}, 32'd0);
      end
      #2 rst_n = 1'b0;
      #1;
      checkOutput("mw_rst_rdy", {31'd0, kon_ready}, 32'd1);
      checkOutput("mw_rst_out", {24'd0, keyon, kon_pulse, koff_pulse, out_op, out_ch}, 32'd0);
      #4 rst_n = 1'b1;
      exp_cnt = '0;
      for (int k = 1; k <= 64; k++) begin
         tick();
         checkDut1("post_rst", 1'b0, 1'b0, 1'b0);
         checkOutput("post_rst_rdy", {31'd0, kon_ready}, 32'd1);
      end

      // CH_W=2/OP_W=3: mask bit1 selects op4 (bitrev 100 = 001) => slot 4*4+1 = 17
      $display("[TB] geometry 2/3");
      kon2_valid = 1'b1;
      kon2_ch    = 2'd1;
      kon2_op    = 8'b0000_0010;
      for (int k = 1; k <= 64; k++) begin
         tick();
         if (k == 1) kon2_valid = 1'b0;
         hit = (out_slot == 5'd17);
         checkOutput("g23_slot", {27'd0, out2_op, out2_ch}, {27'd0, out_slot});
         checkOutput("g23_key", {29'd0, keyon2, kon2_pulse, koff2_pulse},
                     {29'd0, hit, hit && (k <= 32), 1'b0});
         checkOutput("g23_rdy", {31'd0, kon2_ready}, {31'd0, k > 32});
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/jt51_kon_gen.md
# jt51_kon_gen

Parametrised key-on sequencer, the successor of the fixed 8-channel × 4-operator key-on tracker. It owns its own slot counter and stores per-slot key state in a reset-capable circular shifter. It accepts key-on writes through a valid/ready handshake and applies CSM (timer-A overflow) forcing. It emits per-slot key level plus key-on and key-off edge pulses for the envelope generator.

## Interface
- `CH_W`, default 3: channel index width; channels = 2^CH_W.
- `OP_W`, default 2: operator index width; operators per channel = 2^OP_W.
- `CSM_EN`, default 1: when 0, `csm` and `overflow_A` are ignored and the CSM logic is removed.
- `clk` in 1: system clock; all state advances only on cycles with `clk_en`=1.
- `rst_n` in 1: reset; asynchronous, active-low.
- `clk_en` in 1: slot-rate enable.
- `kon_valid` in 1: key-on write request.
- `kon_ready` out 1: write can be accepted.
- `kon_ch` in CH_W: target channel.
- `kon_op` in 2^OP_W: per-operator key mask for the target channel.
- `csm` in 1: CSM mode enable.
- `overflow_A` in 1: timer-A overflow strobe.
- `out_ch` out CH_W: channel of the slot on the outputs.
- `out_op` out OP_W: operator of the slot on the outputs.
- `keyon` out 1: key level for that slot, after CSM forcing.
- `kon_pulse` out 1: `keyon` 0→1 for that slot since its previous visit.
- `koff_pulse` out 1: `keyon` 1→0 for that slot since its previous visit.

## Operation
- Slot counter:
  - Width S = OP_W+CH_W; SLOTS = 2^S.
  - Slot = {op, ch}, so the channel field increments fastest.
  - Increments by 1 per `clk_en` and wraps from SLOTS−1 to 0.
- Operator bit select: the current slot reads `kon_op[bitrev(op)]`, where bitrev reverses the OP_W-bit index. For OP_W=2 this gives op 0,1,2,3 → mask bits 0,2,1,3.
- Storage: a 2-bit × SLOTS circular shifter; each entry is {stored_key, prev_out}.
- Write handshake:
  - A write is accepted when `kon_valid && kon_ready && clk_en`. The block latches ch, mask and acc_slot (the current counter value), sets `pending`, and drops `kon_ready`.
  - While `pending` is set, every slot whose ch equals the latched ch takes stored_key = mask bit; all other slots recirculate unchanged.
  - `pending` clears when the counter next equals acc_slot, i.e. after exactly SLOTS enabled cycles. `kon_ready` rises in that same cycle.
  - The acceptance-cycle slot is itself updated.
- CSM (CSM_EN=1):
  - `overflow_A` with `clk_en` sets `csm_act` and records ov_slot = current counter.
  - `csm_act` clears when the counter returns to ov_slot without a new overflow.
  - A new overflow while `csm_act` is set re-records ov_slot, extending the window.
  - Effective key = stored_key | (`csm` & `csm_act`).
  - CSM forcing never modifies stored_key.
- Edges: `kon_pulse` = eff & !prev_out; `koff_pulse` = !eff & prev_out. prev_out is then written with eff.
- Simultaneous events: an accepted write and an overflow in the same cycle are both honoured. `kon_valid` held while `kon_ready`=0 is ignored and is not queued.

## Timing
- Outputs are registered. `keyon`, the pulses, `out_ch` and `out_op` all describe the slot the counter held on the previous enabled cycle.
- A write reaches the output for a matching slot at most SLOTS+1 enabled cycles after acceptance.
- Reset (asynchronous, any time, including mid-write):
  - Counter = 0, all storage = 0, `pending`=0, `csm_act`=0.
  - `kon_ready`=1.
  - `keyon`, `kon_pulse`, `koff_pulse`, `out_ch`, `out_op` = 0.
- `clk_en`=0 freezes all state, including `kon_ready`.

## Structure
- Package `jt51_kon_pkg` holds:
  - the default `CH_W`/`OP_W` constants;
  - the slot struct {op, ch};
  - the `bitrev` function.
- Sub-module `jt51_sh_rst`: a parametrised-width/depth shifter with `clk_en` and asynchronous active-low reset, instantiated at width 2, depth SLOTS.

## Test plan
- Reset, defaults (3/2): release `rst_n` → `kon_ready`=1; all outputs 0 for 64 enabled cycles.
- Write ch 5, mask 4'b0101 → `kon_pulse` only for op0 (ch5) and op1 (ch5, mask bit2); `kon_ready` low for exactly 32 enabled cycles.
- Write ch 5, mask 0 after the previous step → `koff_pulse` on the same two slots; `keyon`=0 thereafter.
- CSM: `csm`=1, one `overflow_A` pulse → `keyon`=1 for all 32 slots for one sweep, then returns to stored values; a second overflow mid-sweep extends the window to 32 cycles from the new overflow.
- Reset asserted mid-write (cycle 10 of pending) → immediate clear; after release, the earlier write has no effect.
- CH_W=2, OP_W=3, mask 8'b0000_0010 on ch 1 → only op4 (bitrev(100)=001) of ch 1 keys on; SLOTS=32 wrap verified.
